buf_arbiter: RTL
================

BUF_ARBITER -- requirements
Module: buf_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AW, 8, address width; DW, 32, data width; TO_CYC, 16, MEM_ACK timeout in clock cycles (legal range 2..255).
REQ-002 Ports SHALL be (name, direction, width, meaning), as follows.
REQ-003 WB_CLK_I, in, 1, single clock; all logic on its rising edge.
REQ-004 WB_RST_I, in, 1, reset; synchronous, active-low.
REQ-005 A_REQ_I / B_REQ_I, in, 1, access request from port A (Wishbone side) / port B (SPI side).
REQ-006 A_WE_I / B_WE_I, in, 1, 1=write, 0=read.
REQ-007 A_ADR_I / B_ADR_I, in, AW, buffer address.
REQ-008 A_DAT_I / B_DAT_I, in, DW, write data.
REQ-009 A_ACK_O / B_ACK_O, out, 1, one-cycle completion pulse.
REQ-010 A_ERR_O / B_ERR_O, out, 1, qualifies ACK: access timed out.
REQ-011 RD_DAT_O, out, DW, read data, shared, valid during any ACK.
REQ-012 MEM_REQ_O, out, 1, buffer access strobe.
REQ-013 MEM_WR_O, out, 1, buffer write enable.
REQ-014 MEM_ADR_O, out, AW, buffer address.
REQ-015 MEM_DAT_O, out, DW, buffer write data.
REQ-016 MEM_DAT_I, in, DW, buffer read data.
REQ-017 MEM_ACK_I, in, 1, buffer completion.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-019 In IDLE with any REQ high, the block SHALL select one port, register its WE/ADR/DAT into MEM_WR_O/MEM_ADR_O/MEM_DAT_O, assert MEM_REQ_O, clear the timeout counter and go to ACCESS (MEM_REQ_O high one cycle after REQ is sampled).
REQ-020 Selection SHALL be round-robin: when both REQs are high, the port not granted last wins; a single request wins regardless of history.
REQ-021 In ACCESS, MEM_REQ_O and the MEM_* outputs SHALL be held stable until MEM_ACK_I=1 or timeout.
REQ-022 On MEM_ACK_I=1 in ACCESS, the block SHALL capture MEM_DAT_I into RD_DAT_O (capture on reads only), deassert MEM_REQ_O and MEM_WR_O, and go to RESP.
REQ-023 Timeout SHALL occur when the counter reaches TO_CYC-1 in ACCESS without MEM_ACK_I; the block SHALL then go to RESP with ERR set and RD_DAT_O=0.
REQ-024 MEM_ACK_I arriving in the same cycle as the timeout SHALL win, giving no error.
REQ-025 In RESP, the granted port's ACK_O SHALL be high for exactly one cycle, with ERR_O valid in the same cycle, and the FSM SHALL return to IDLE.
REQ-026 Latency SHALL be REQ sampled (cycle n), MEM_REQ_O at n+1, MEM_ACK_I at n+k, ACK_O at n+k+1.
REQ-027 A REQ still high in the first IDLE cycle after ACK SHALL be treated as a new request; requesters drop REQ on seeing ACK.
REQ-028 MEM_ACK_I in IDLE or RESP SHALL be ignored.
REQ-029 A REQ dropped during ACCESS SHALL NOT abort the access; the ACK is still issued.
REQ-030 The non-granted port's ACK_O and ERR_O SHALL remain 0.

Reset
REQ-031 With WB_RST_I=0 at a clock edge, the block SHALL enter IDLE and drive all outputs to 0: MEM_REQ_O, MEM_WR_O, MEM_ADR_O, MEM_DAT_O, A/B_ACK_O, A/B_ERR_O, RD_DAT_O.
REQ-032 Reset SHALL set the round-robin pointer so that port A wins the first contended grant, and SHALL clear the timeout counter.
REQ-033 Reset asserted in ACCESS or RESP SHALL abort the access with no ACK issued.

Structure
REQ-034 A package buf_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), port-select encoding (PORT_A=0, PORT_B=1) and default parameter constants.
REQ-035 The 2-way round-robin picker SHALL be a sub-module buf_arb_rr (inputs: two requests, last grant; output: grant), combinational with no state.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Scenario: A write ADR=0x10, DAT=0xA5A5A5A5; MEM_ACK 3 cycles after MEM_REQ -> MEM_WR=1 and ADR/DAT stable until ACK; A_ACK one cycle, A_ERR=0.
REQ-038 Scenario: B read ADR=0x22, MEM_DAT_I=0x12345678 -> RD_DAT_O=0x12345678 with B_ACK; A_ACK stays 0.
REQ-039 Scenario: A and B held high for 4 accesses after reset -> grant order A,B,A,B.
REQ-040 Scenario: no MEM_ACK, TO_CYC=16 -> ACK with ERR=1 and RD_DAT_O=0 sixteen cycles after MEM_REQ rises; MEM_ACK on cycle TO_CYC-1 -> ERR=0.
REQ-041 Scenario: reset pulsed while in ACCESS -> all outputs 0 next cycle, no ACK; next contended request granted to A.

Source files
------------

// File: rtl/buf_arb_pkg.sv
// Shared types and default constants for the buffer arbiter.
//   state_t : arbiter FSM states (IDLE, ACCESS, RESP)
//   port_t  : port-select encoding (PORT_A = Wishbone side, PORT_B = SPI side)
//   *_DEF   : default values for the arbiter parameters
package buf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam int AW_DEF     = 8;
    localparam int DW_DEF     = 32;
    localparam int TO_CYC_DEF = 16;

endpackage

// File: rtl/buf_arb_rr.sv
// Two-way round-robin picker, purely combinational.
//   i_a_req / i_b_req : requests from port A / port B
//   i_last            : port granted most recently
//   o_grant           : selected port (only meaningful when a request is high)
module buf_arb_rr
    import buf_arb_pkg::*;
(
    input  logic  i_a_req,
    input  logic  i_b_req,
    input  port_t i_last,
    output port_t o_grant
);

    always_comb begin
        o_grant = PORT_A;
        if (i_a_req && i_b_req) begin
            // Contention: the port that did not win last time goes next.
            o_grant = (i_last == PORT_A) ? PORT_B : PORT_A;
        end else if (i_b_req) begin
            o_grant = PORT_B;
        end
    end

endmodule

// File: rtl/buf_arbiter.sv
// Arbitrates two requesters (A: Wishbone side, B: SPI side) onto a single
// buffer memory port with round-robin selection and an ACK timeout.
//   WB_CLK_I, WB_RST_I (sync, active-low)
//   A_/B_ REQ_I, WE_I, ADR_I, DAT_I : per-port request
//   A_/B_ ACK_O, ERR_O              : per-port one-cycle completion (+timeout flag)
//   RD_DAT_O                        : shared read data, valid with any ACK
//   MEM_REQ_O, MEM_WR_O, MEM_ADR_O, MEM_DAT_O, MEM_DAT_I, MEM_ACK_I : buffer side
// All outputs are registered.
module buf_arbiter
    import buf_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic          WB_CLK_I,
    input  logic          WB_RST_I,
    input  logic          A_REQ_I,
    input  logic          A_WE_I,
    input  logic [AW-1:0] A_ADR_I,
    input  logic [DW-1:0] A_DAT_I,
    output logic          A_ACK_O,
    output logic          A_ERR_O,
    input  logic          B_REQ_I,
    input  logic          B_WE_I,
    input  logic [AW-1:0] B_ADR_I,
    input  logic [DW-1:0] B_DAT_I,
    output logic          B_ACK_O,
    output logic          B_ERR_O,
    output logic [DW-1:0] RD_DAT_O,
    output logic          MEM_REQ_O,
    output logic          MEM_WR_O,
    output logic [AW-1:0] MEM_ADR_O,
    output logic [DW-1:0] MEM_DAT_O,
    input  logic [DW-1:0] MEM_DAT_I,
    input  logic          MEM_ACK_I
);

    // Last counter value before the access is declared timed out.
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    state_t        r_state, w_state_nxt;
    port_t         r_last,  w_last_nxt;   // current/most recent grant
    port_t         w_rr_gnt;
    logic [7:0]    r_cnt,   w_cnt_nxt;
    logic          r_mem_req, w_mem_req_nxt;
    logic          r_mem_wr,  w_mem_wr_nxt;
    logic [AW-1:0] r_mem_adr, w_mem_adr_nxt;
    logic [DW-1:0] r_mem_dat, w_mem_dat_nxt;
    logic [DW-1:0] r_rd_dat,  w_rd_dat_nxt;
    logic          r_a_ack, w_a_ack_nxt;
    logic          r_b_ack, w_b_ack_nxt;
    logic          r_a_err, w_a_err_nxt;
    logic          r_b_err, w_b_err_nxt;

    buf_arb_rr u_rr (
        .i_a_req (A_REQ_I),
        .i_b_req (B_REQ_I),
        .i_last  (r_last),
        .o_grant (w_rr_gnt)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_mem_req_nxt = r_mem_req;
        w_mem_wr_nxt  = r_mem_wr;
        w_mem_adr_nxt = r_mem_adr;
        w_mem_dat_nxt = r_mem_dat;
        w_rd_dat_nxt  = r_rd_dat;
        w_a_ack_nxt   = 1'b0;
        w_a_err_nxt   = 1'b0;
        w_b_ack_nxt   = 1'b0;
        w_b_err_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (A_REQ_I || B_REQ_I) begin
                    w_last_nxt    = w_rr_gnt;
                    w_mem_req_nxt = 1'b1;
                    w_mem_wr_nxt  = (w_rr_gnt == PORT_B) ? B_WE_I  : A_WE_I;
                    w_mem_adr_nxt = (w_rr_gnt == PORT_B) ? B_ADR_I : A_ADR_I;
                    w_mem_dat_nxt = (w_rr_gnt == PORT_B) ? B_DAT_I : A_DAT_I;
                    w_cnt_nxt     = 8'd0;
                    w_state_nxt   = ACCESS;
                end
            end
            ACCESS: begin
                // MEM_ACK_I is tested first so it wins over a same-cycle timeout.
                if (MEM_ACK_I) begin
                    if (!r_mem_wr) begin
                        w_rd_dat_nxt = MEM_DAT_I;
                    end
                    w_mem_req_nxt = 1'b0;
                    w_mem_wr_nxt  = 1'b0;
                    w_a_ack_nxt   = (r_last == PORT_A);
                    w_b_ack_nxt   = (r_last == PORT_B);
                    w_state_nxt   = RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_rd_dat_nxt  = '0;
                    w_mem_req_nxt = 1'b0;
                    w_mem_wr_nxt  = 1'b0;
                    w_a_ack_nxt   = (r_last == PORT_A);
                    w_b_ack_nxt   = (r_last == PORT_B);
                    w_a_err_nxt   = (r_last == PORT_A);
                    w_b_err_nxt   = (r_last == PORT_B);
                    w_state_nxt   = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            RESP: begin
                // ACK/ERR are high during this state; defaults clear them.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge WB_CLK_I) begin
        if (!WB_RST_I) begin
            r_state   <= IDLE;
            r_last    <= PORT_B;   // so port A wins the first contended grant
            r_cnt     <= 8'd0;
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_mem_adr <= '0;
            r_mem_dat <= '0;
            r_rd_dat  <= '0;
            r_a_ack   <= 1'b0;
            r_a_err   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_b_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mem_req <= w_mem_req_nxt;
            r_mem_wr  <= w_mem_wr_nxt;
            r_mem_adr <= w_mem_adr_nxt;
            r_mem_dat <= w_mem_dat_nxt;
            r_rd_dat  <= w_rd_dat_nxt;
            r_a_ack   <= w_a_ack_nxt;
            r_a_err   <= w_a_err_nxt;
            r_b_ack   <= w_b_ack_nxt;
            r_b_err   <= w_b_err_nxt;
        end
    end

    assign A_ACK_O   = r_a_ack;
    assign A_ERR_O   = r_a_err;
    assign B_ACK_O   = r_b_ack;
    assign B_ERR_O   = r_b_err;
    assign RD_DAT_O  = r_rd_dat;
    assign MEM_REQ_O = r_mem_req;
    assign MEM_WR_O  = r_mem_wr;
    assign MEM_ADR_O = r_mem_adr;
    assign MEM_DAT_O = r_mem_dat;

endmodule
